// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arbiter
// Description : Round-robin share of one combinational ALU between two
//               requesters. Accepts one request, drives the ALU for one
//               cycle, captures result/zero and returns them to the winner.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_alu_op,
    input  logic [2:0]       req0_func3,
    input  logic [6:0]       req0_func7,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_alu_op,
    input  logic [2:0]       req1_func3,
    input  logic [6:0]       req1_func7,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_zero,
    output logic [1:0]       alu_operation,
    output logic [2:0]       func3,
    output logic [6:0]       func7,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_prio;
    logic             r_grant;
    logic [1:0]       r_op;
    logic [2:0]       r_func3;
    logic [6:0]       r_func7;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_resp_data;
    logic             r_resp_zero;
    logic             w_winner;
    logic             w_accept;
    logic             w_resp_done;

    // Winner: the priority pointer under contention, otherwise whichever is valid
    always_comb begin
        w_winner = 1'b0;
        if (req0_valid && req1_valid) begin
            w_winner = r_prio;
        end else if (req1_valid) begin
            w_winner = 1'b1;
        end
    end

    // Next-state and handshake outputs; readies also held low while in reset
    always_comb begin
        w_state_next = r_state;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        resp0_valid  = 1'b0;
        resp1_valid  = 1'b0;
        w_accept     = 1'b0;
        w_resp_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req0_ready = rst_n && req0_valid && !w_winner;
                req1_ready = rst_n && req1_valid &&  w_winner;
                w_accept   = req0_ready || req1_ready;
                if (w_accept) begin
                    w_state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_next = ST_RESP;
            end
            ST_RESP: begin
                resp0_valid = !r_grant;
                resp1_valid =  r_grant;
                w_resp_done = r_grant ? resp1_ready : resp0_ready;
                if (w_resp_done) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Grant records the accepted requester; priority flips only on response completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant <= 1'b0;
            r_prio  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_grant <= req1_ready;
            end
            if (w_resp_done) begin
                r_prio <= ~r_grant;
            end
        end
    end

    // Issue registers: latch the winner's fields on acceptance, hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op    <= 2'b00;
            r_func3 <= 3'b000;
            r_func7 <= 7'b0000000;
            r_a     <= '0;
            r_b     <= '0;
        end else if (w_accept) begin
            r_op    <= req1_ready ? req1_alu_op : req0_alu_op;
            r_func3 <= req1_ready ? req1_func3  : req0_func3;
            r_func7 <= req1_ready ? req1_func7  : req0_func7;
            r_a     <= req1_ready ? req1_a      : req0_a;
            r_b     <= req1_ready ? req1_b      : req0_b;
        end
    end

    // Capture the ALU result and its own zero flag at the end of the execute cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_data <= '0;
            r_resp_zero <= 1'b0;
        end else if (r_state == ST_EXEC) begin
            r_resp_data <= alu_result;
            r_resp_zero <= alu_zero;
        end
    end

    assign alu_operation = r_op;
    assign func3         = r_func3;
    assign func7         = r_func7;
    assign alu_a         = r_a;
    assign alu_b         = r_b;
    assign resp_data     = r_resp_data;
    assign resp_zero     = r_resp_zero;

endmodule
`default_nettype wire

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares one combinational ALU datapath (driven through `alu_control`) between two requesters, such as the integer pipeline and a multi-cycle address/branch unit. Arbitration is round-robin with valid/ready handshakes on each side. The block latches the winning request's opcode fields and operands and presents them to the ALU for one full cycle. It then captures the result and zero flag and returns them to the winner over a per-requester response handshake.

## Interface
- `WIDTH`, 32, operand/result width
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `req0_valid`, `req1_valid`  in  1  request pending
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle when high with valid
- `req0_alu_op`, `req1_alu_op`  in  2  ALU operation class (00 add, 01 sub, 10 R-type)
- `req0_func3`, `req1_func3`  in  3  instruction func3
- `req0_func7`, `req1_func7`  in  7  instruction func7
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  WIDTH  operands
- `resp0_valid`, `resp1_valid`  out  1  result available
- `resp0_ready`, `resp1_ready`  in  1  requester consumes result
- `resp_data`  out  WIDTH  result register (shared, qualified by `respN_valid`)
- `resp_zero`  out  1  registered zero flag
- `alu_operation`  out  2  to `alu_control`
- `func3`  out  3  to `alu_control`
- `func7`  out  7  to `alu_control`
- `alu_a`, `alu_b`  out  WIDTH  to ALU
- `alu_result`  in  WIDTH  from ALU (combinational from `alu_a`/`alu_b`/control)
- `alu_zero`  in  1  from ALU

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - `reqN_ready` is high only for the grant winner, and only while `reqN_valid` is high.
  - Winner selection:
    - If one requester is valid, it wins.
    - If both are valid, the requester selected by the priority pointer `prio` wins.
  - On handshake: latch op/func3/func7/a/b into the issue registers, record `grant` = winner index, go to EXEC.
- EXEC:
  - Issue registers drive `alu_operation`, `func3`, `func7`, `alu_a`, `alu_b`.
  - At the end of the cycle, capture `alu_result` → `resp_data` and `alu_zero` → `resp_zero`, then go to RESP.
  - No `reqN_ready` is asserted.
- RESP:
  - `resp[grant]_valid` = 1; the other response valid stays 0.
  - Hold `resp_data`, `resp_zero` and the issue registers stable until `resp[grant]_ready`.
  - On ready: go to IDLE and set `prio` = ~`grant`.
- Issue registers hold their last value outside EXEC; the ALU inputs are don't-care outside EXEC.
- `prio` changes only on response completion, never on request acceptance.
- Requester validity:
  - Requests must hold stable while valid and not ready.
  - `reqN_valid` may deassert without a handshake; the block then must not grant it.
- Only one transaction is in flight at a time; no pipelining between requesters.

## Timing
- Reset (async assert, sync release) values:
  - State = IDLE, `prio` = 0, `grant` = 0.
  - Issue registers, `resp_data` and `resp_zero` = 0.
  - `alu_operation` = 00, `func3` = 0, `func7` = 0, `alu_a` = `alu_b` = 0.
  - All `reqN_ready` = 0 and all `respN_valid` = 0 while `rst_n` is low.
- Latency:
  - A request accepted in cycle N is driven to the ALU in N+1.
  - `respN_valid` is high from N+2.
  - Minimum back-to-back throughput is one transaction per 3 cycles, when `resp_ready` is held high.
- `reqN_ready` is combinational from the state, `reqN_valid` and `prio`. It has no combinational path from any `resp*_ready`.
- The next request can be accepted in the cycle after the response handshake (IDLE), not in the same cycle.
- Simultaneous valid from both requesters in IDLE: exactly one ready is asserted, to `prio`.
- Reset mid-transaction: the response is dropped (`respN_valid` falls immediately) and the FSM returns to IDLE with `prio` = 0.
- `resp_zero` reflects the ALU zero flag for the captured result, not a recomputed compare.

## Test plan
- Single add, requester 0: `req0` op=00, a=5, b=7 → `req0_ready` in cycle N; `alu_operation`=00, `alu_a`=5 in N+1; `resp0_valid` with `resp_data`=12, `resp_zero`=0 in N+2; `resp1_valid` stays 0.
- R-type sub giving zero, requester 1: op=10, func3=000, func7=0100000, a=b=9 → `func7`=0100000 in EXEC, `resp_data`=0, `resp_zero`=1.
- Contention fairness:
  - Both requesters held valid continuously, with `resp*_ready`=1 every cycle.
  - Grants alternate 0,1,0,1 starting from 0 after reset.
  - A new acceptance occurs every 3 cycles.
- Response backpressure:
  - `resp0_ready`=0 for 5 cycles while `req1_valid`=1.
  - `resp_data` and `alu_a` stay stable throughout, and `req1_ready` stays 0.
  - `req1` is accepted in the cycle after `resp0_ready` rises.
- Reset mid-RESP: assert `rst_n`=0 while `resp0_valid`=1 → `resp0_valid`=0 immediately, `resp_data`=0; after release the first contended grant goes to requester 0.
- R-type AND/OR: func3=111, a=0xF0F0, b=0xFF00 → 0xF000; then func3=110 → 0xFFF0.
